// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SADD = 4'b1011;
    localparam logic [3:0] ALU_SSUB = 4'b1100;

    localparam logic [1:0] SRC_A_PC = 2'b00;
    localparam logic [1:0] SRC_A_RS = 2'b01;
    localparam logic [1:0] SRC_A_RT = 2'b10;

    localparam logic [2:0] SRC_B_RT       = 3'b000;
    localparam logic [2:0] SRC_B_FOUR     = 3'b001;
    localparam logic [2:0] SRC_B_SEXT     = 3'b010;
    localparam logic [2:0] SRC_B_SEXT_SH2 = 3'b011;
    localparam logic [2:0] SRC_B_ZEXT     = 3'b100;
    localparam logic [2:0] SRC_B_SHAMT    = 3'b101;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_EXC    = 2'b11;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_OVF     = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL = 2'b10;

    localparam logic [3:0] S_RESET     = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXEC_R    = 4'd7;
    localparam logic [3:0] S_EXEC_I    = 4'd8;
    localparam logic [3:0] S_ALU_WB    = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;
    localparam logic [3:0] S_EXCEPT    = 4'd12;

    // Only the trapping add/sub forms raise an overflow exception.
    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == ALU_SADD) || (op == ALU_SSUB);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_op_decode.sv
// rtl/mips_multicycle_ctrl_alu_op_decode.sv - IR opcode/funct to ALU operator and operand selects
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic [1:0] src_a_o,
    output logic [2:0] src_b_o,
    output logic       is_signed_o,
    output logic       legal_o
);

    logic [3:0] alu_op;
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic       legal;

    always_comb begin
        alu_op = ALU_AND;
        src_a  = SRC_A_PC;
        src_b  = SRC_B_RT;
        legal  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                src_a = SRC_A_RS;
                src_b = SRC_B_RT;
                legal = 1'b1;
                case (funct_i)
                    FN_ADD:  alu_op = ALU_SADD;
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SSUB;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        alu_op = (funct_i == FN_SLL) ? ALU_SLL :
                                 (funct_i == FN_SRL) ? ALU_SRL : ALU_SRA;
                        src_a  = SRC_A_RT;
                        src_b  = SRC_B_SHAMT;
                    end
                    default: begin
                        alu_op = ALU_AND;
                        src_a  = SRC_A_PC;
                        legal  = 1'b0;
                    end
                endcase
            end
            OP_ADDI:  begin alu_op = ALU_SADD; src_a = SRC_A_RS; src_b = SRC_B_SEXT; legal = 1'b1; end
            OP_ADDIU: begin alu_op = ALU_ADD;  src_a = SRC_A_RS; src_b = SRC_B_SEXT; legal = 1'b1; end
            OP_ANDI:  begin alu_op = ALU_AND;  src_a = SRC_A_RS; src_b = SRC_B_ZEXT; legal = 1'b1; end
            OP_ORI:   begin alu_op = ALU_OR;   src_a = SRC_A_RS; src_b = SRC_B_ZEXT; legal = 1'b1; end
            OP_XORI:  begin alu_op = ALU_XOR;  src_a = SRC_A_RS; src_b = SRC_B_ZEXT; legal = 1'b1; end
            OP_SLTI:  begin alu_op = ALU_SLT;  src_a = SRC_A_RS; src_b = SRC_B_SEXT; legal = 1'b1; end
            OP_LW, OP_SW: begin
                alu_op = ALU_ADD;
                src_a  = SRC_A_RS;
                src_b  = SRC_B_SEXT;
                legal  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_op = ALU_SUB;
                src_a  = SRC_A_RS;
                src_b  = SRC_B_RT;
                legal  = 1'b1;
            end
            OP_J:    legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign alu_op_o    = alu_op;
    assign src_a_o     = src_a;
    assign src_b_o     = src_b;
    assign legal_o     = legal;
    assign is_signed_o = is_signed_op(alu_op);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM driving ALU, PC, IR, regfile and memory
module mips_multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_zero,
    input  logic                alu_overflow,
    input  logic                mem_ready,
    output logic [ALU_OP_W-1:0] alu_operator,
    output logic [1:0]          alu_src_a,
    output logic [2:0]          alu_src_b,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                exception,
    output logic [1:0]          exc_cause
);

    logic [3:0] state_q, state_d;
    logic       ovf_q, ovf_d;
    logic [1:0] exc_cause_q, exc_cause_d;

    logic [3:0] dec_alu_op;
    logic [1:0] dec_src_a;
    logic [2:0] dec_src_b;
    logic       dec_is_signed;
    logic       dec_legal;

    alu_op_decode u_alu_op_decode (
        .opcode_i    (opcode),
        .funct_i     (funct),
        .alu_op_o    (dec_alu_op),
        .src_a_o     (dec_src_a),
        .src_b_o     (dec_src_b),
        .is_signed_o (dec_is_signed),
        .legal_o     (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RESET;
            ovf_q       <= 1'b0;
            exc_cause_q <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    // The cause is latched on entry so it is already visible during EXCEPT.
    always_comb begin
        state_d     = state_q;
        ovf_d       = ovf_q;
        exc_cause_d = exc_cause_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ADDI, OP_ADDIU, OP_ANDI,
                    OP_ORI, OP_XORI, OP_SLTI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default: begin
                        state_d     = S_EXCEPT;
                        exc_cause_d = EXC_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC_R: begin
                if (!dec_legal) begin
                    state_d     = S_EXCEPT;
                    exc_cause_d = EXC_ILLEGAL;
                end else begin
                    ovf_d   = alu_overflow;
                    state_d = S_ALU_WB;
                end
            end
            S_EXEC_I: begin
                ovf_d   = alu_overflow;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                if (ovf_q && dec_is_signed) begin
                    state_d     = S_EXCEPT;
                    exc_cause_d = EXC_OVF;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_BRANCH, S_JUMP, S_EXCEPT: state_d = S_FETCH;
            default: state_d = S_RESET;
        endcase
    end

    logic [3:0] alu_op;

    always_comb begin
        alu_op     = ALU_AND;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RT;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        exception  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_op    = ALU_ADD;
                alu_src_b = SRC_B_FOUR;
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_op    = ALU_ADD;
                alu_src_b = SRC_B_SEXT_SH2;
            end
            S_MEM_ADDR: begin
                alu_op    = ALU_ADD;
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_SEXT;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_op    = dec_alu_op;
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
            end
            S_ALU_WB: begin
                reg_write = !(ovf_q && dec_is_signed);
                reg_dst   = (opcode == OP_RTYPE);
            end
            S_BRANCH: begin
                alu_op    = ALU_SUB;
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_RT;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = alu_zero ^ (opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
            end
            S_EXCEPT: begin
                exception = 1'b1;
                pc_src    = PC_SRC_EXC;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_operator = ALU_OP_W'(alu_op);
    assign exc_cause    = exc_cause_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed bench for the multi-cycle MIPS control FSM
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_overflow;
    logic       mem_ready;
    logic [3:0] alu_operator;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       exception;
    logic [1:0] exc_cause;

    int n_cmp = 0;
    int n_err = 0;

    mips_multicycle_ctrl #(.ALU_OP_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct        (funct),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .mem_ready    (mem_ready),
        .alu_operator (alu_operator),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .iord         (iord),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .exception    (exception),
        .exc_cause    (exc_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] obs;
    assign obs = {alu_operator, alu_src_a, alu_src_b, mem_read, mem_write, iord, ir_write,
                  pc_write, pc_src, reg_write, reg_dst, mem_to_reg, exception, exc_cause};

    function automatic logic [21:0] v(input logic [3:0] op, input logic [1:0] sa, input logic [2:0] sb,
                                      input logic mr, input logic mw, input logic io, input logic irw,
                                      input logic pcw, input logic [1:0] pcs, input logic rw,
                                      input logic rd, input logic m2r, input logic ex, input logic [1:0] c);
        return {op, sa, sb, mr, mw, io, irw, pcw, pcs, rw, rd, m2r, ex, c};
    endfunction

    function automatic logic [21:0] e_fetch(input logic r, input logic [1:0] c);
        return v(4'b0010, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, r, r, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_decode(input logic [1:0] c);
        return v(4'b0010, 2'b00, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_memaddr(input logic [1:0] c);
        return v(4'b0010, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_memrd(input logic [1:0] c);
        return v(4'b0000, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_memwb(input logic [1:0] c);
        return v(4'b0000, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_memwr(input logic [1:0] c);
        return v(4'b0000, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_exec(input logic [3:0] op, input logic [1:0] sa, input logic [2:0] sb,
                                           input logic [1:0] c);
        return v(op, sa, sb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_aluwb(input logic rw, input logic rd, input logic [1:0] c);
        return v(4'b0000, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, rw, rd, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_branch(input logic p, input logic [1:0] c);
        return v(4'b0110, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, p, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_jump(input logic [1:0] c);
        return v(4'b0000, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [21:0] e_except(input logic [1:0] c);
        return v(4'b0000, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, c);
    endfunction

    task automatic chk(input string tag, input logic [21:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH; returns one cycle into the state after DECODE.
    task automatic fetch_decode(input string name, input logic [5:0] op, input logic [5:0] fn,
                                input logic [1:0] c);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        #1 chk({name, "_fetch"}, e_fetch(1'b1, c));
        nxt();
        mem_ready = 1'b0;
        #1 chk({name, "_decode"}, e_decode(c));
        nxt();
    endtask

    initial begin
        rst = 1'b1; opcode = 6'd0; funct = 6'd0;
        alu_zero = 1'b0; alu_overflow = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset_hold", 22'd0);
        rst = 1'b0;
        #1 chk("reset_state", 22'd0);
        nxt();

        fetch_decode("lw", 6'b100011, 6'd0, 2'b00);
        #1 chk("lw_mem_addr", e_memaddr(2'b00));
        for (int i = 0; i < 4; i++) begin
            nxt();
            mem_ready = (i == 3);
            #1 chk("lw_mem_read", e_memrd(2'b00));
        end
        nxt();
        mem_ready = 1'b0;
        #1 chk("lw_mem_wb", e_memwb(2'b00));
        nxt();

        fetch_decode("add", 6'b000000, 6'b100000, 2'b00);
        alu_overflow = 1'b1;
        #1 chk("add_exec_r", e_exec(4'b1011, 2'b01, 3'b000, 2'b00));
        nxt();
        alu_overflow = 1'b0;
        #1 chk("add_ovf_alu_wb", e_aluwb(1'b0, 1'b1, 2'b00));
        nxt();
        #1 chk("add_ovf_except", e_except(2'b01));
        nxt();

        opcode = 6'b000000; funct = 6'b000000; mem_ready = 1'b0;
        #1 chk("fetch_wait", e_fetch(1'b0, 2'b01));
        nxt();
        #1 chk("fetch_wait_hold", e_fetch(1'b0, 2'b01));
        fetch_decode("sll", 6'b000000, 6'b000000, 2'b01);
        #1 chk("sll_exec_r", e_exec(4'b1000, 2'b10, 3'b101, 2'b01));
        nxt();
        #1 chk("sll_alu_wb", e_aluwb(1'b1, 1'b1, 2'b01));
        nxt();

        fetch_decode("beq", 6'b000100, 6'd0, 2'b01);
        alu_zero = 1'b1;
        #1 chk("beq_taken", e_branch(1'b1, 2'b01));
        alu_zero = 1'b0;
        #1 chk("beq_not_taken", e_branch(1'b0, 2'b01));
        nxt();

        fetch_decode("bne", 6'b000101, 6'd0, 2'b01);
        alu_zero = 1'b0;
        #1 chk("bne_taken", e_branch(1'b1, 2'b01));
        alu_zero = 1'b1;
        #1 chk("bne_not_taken", e_branch(1'b0, 2'b01));
        alu_zero = 1'b0;
        nxt();

        fetch_decode("j", 6'b000010, 6'd0, 2'b01);
        #1 chk("j_jump", e_jump(2'b01));
        nxt();

        fetch_decode("addiu", 6'b001001, 6'd0, 2'b01);
        alu_overflow = 1'b1;
        #1 chk("addiu_exec_i", e_exec(4'b0010, 2'b01, 3'b010, 2'b01));
        nxt();
        alu_overflow = 1'b0;
        #1 chk("addiu_ovf_ignored", e_aluwb(1'b1, 1'b0, 2'b01));
        nxt();

        fetch_decode("ori", 6'b001101, 6'd0, 2'b01);
        #1 chk("ori_exec_i", e_exec(4'b0001, 2'b01, 3'b100, 2'b01));
        nxt();
        #1 chk("ori_alu_wb", e_aluwb(1'b1, 1'b0, 2'b01));
        nxt();

        fetch_decode("illegal_op", 6'b111111, 6'd0, 2'b01);
        #1 chk("illegal_op_except", e_except(2'b10));
        nxt();

        fetch_decode("addi", 6'b001000, 6'd0, 2'b10);
        alu_overflow = 1'b1;
        #1 chk("addi_exec_i", e_exec(4'b1011, 2'b01, 3'b010, 2'b10));
        nxt();
        alu_overflow = 1'b0;
        #1 chk("addi_ovf_alu_wb", e_aluwb(1'b0, 1'b0, 2'b10));
        nxt();
        #1 chk("addi_ovf_except", e_except(2'b01));
        nxt();

        fetch_decode("bad_funct", 6'b000000, 6'b000001, 2'b01);
        nxt();
        #1 chk("bad_funct_except", e_except(2'b10));
        nxt();

        fetch_decode("sw", 6'b101011, 6'd0, 2'b10);
        #1 chk("sw_mem_addr", e_memaddr(2'b10));
        nxt();
        mem_ready = 1'b0;
        #1 chk("sw_mem_write_wait", e_memwr(2'b10));
        nxt();
        mem_ready = 1'b1;
        #1 chk("sw_mem_write", e_memwr(2'b10));
        nxt();
        mem_ready = 1'b0;
        #1 chk("sw_back_to_fetch", e_fetch(1'b0, 2'b10));

        fetch_decode("lw_rst", 6'b100011, 6'd0, 2'b10);
        nxt();
        #1 chk("lw_rst_mem_read", e_memrd(2'b10));
        rst = 1'b1;
        #1 chk("rst_mid_access", 22'd0);
        nxt();
        #1 chk("rst_held", 22'd0);
        rst = 1'b0;
        #1 chk("rst_release_reset_state", 22'd0);
        nxt();
        #1 chk("rst_release_fetch", e_fetch(1'b0, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM that issues operator codes and operand-mux selects to the datapath ALU and consumes its ret-derived flags (zero, overflow). It sequences fetch/decode/execute/memory/writeback for the MIPS subset, with a ready handshake to unified memory. It takes opcode/funct from the external IR and raises overflow and illegal-instruction exceptions. The external ALUOut register captures the ALU result every cycle.

Parameters:
ALU_OP_W, 4, width of alu_operator (fixed ALU encoding below)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag for the current operator/operands
alu_overflow  in  1  ALU signed-overflow flag
mem_ready  in  1  memory completes the access this cycle
alu_operator  out  4  and 0000, or 0001, add 0010, xor 0011, nor 0100, sub 0110, slt 0111, sll 1000, srl 1001, sra 1010, sadd 1011, ssub 1100
alu_src_a  out  2  00 PC, 01 A(rs), 10 B(rt)
alu_src_b  out  3  000 B, 001 const 4, 010 sext imm, 011 sext imm<<2, 100 zext imm, 101 shamt
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  0 address=PC, 1 address=ALUOut
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  00 ALU ret, 01 ALUOut, 10 jump target, 11 exception vector
reg_write  out  1  register file write
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
exception  out  1  one-cycle pulse in EXCEPT
exc_cause  out  2  01 overflow, 10 illegal; holds until next exception

Behaviour:
- Reset: async, active-high. State RESET; all outputs 0, including exc_cause 00. After rst deasserts, the first clock moves to FETCH.
- Outputs are a Moore decode of the state register and IR fields. Exceptions: pc_write/ir_write in FETCH are gated by mem_ready, and pc_write in BRANCH is gated by alu_zero.
- FETCH: mem_read=1, iord=0, src_a=00, src_b=001, op 0010, pc_src=00. Holds while mem_ready=0. In the mem_ready cycle, ir_write=pc_write=1, then go to DECODE.
- DECODE: src_a=00, src_b=011, op 0010 to compute the branch target into ALUOut. Dispatch:
  - lw 100011 / sw 101011 -> MEM_ADDR
  - R-type 000000 -> EXEC_R
  - addi 001000, addiu 001001, andi 001100, ori 001101, xori 001110, slti 001010 -> EXEC_I
  - beq 000100 / bne 000101 -> BRANCH
  - j 000010 -> JUMP
  - any other opcode -> EXCEPT with cause 10
- MEM_ADDR: src_a=01, src_b=010, op 0010. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1; hold until mem_ready, then MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEM_WRITE: mem_write=1, iord=1; hold until mem_ready, then FETCH.
- EXEC_R: funct map:
  - add 100000->1011, addu 100001->0010, sub 100010->1100, subu 100011->0110
  - and 100100->0000, or 100101->0001, xor 100110->0011, nor 100111->0100, slt 101010->0111
  - these use src_a=01, src_b=000
  - sll 000000->1000, srl 000010->1001, sra 000011->1010; these use src_a=10, src_b=101
  - unknown funct -> EXCEPT, cause 10
  - Otherwise latch ovf_q<=alu_overflow and go to ALU_WB.
- EXEC_I: src_a=01. addi 1011/010, addiu 0010/010, andi 0000/100, ori 0001/100, xori 0011/100, slti 0111/010. Latch ovf_q, then ALU_WB.
- ALU_WB: mem_to_reg=0, reg_dst=1 for R-type else 0.
  - If ovf_q=1 and op is 1011/1100: reg_write=0, go to EXCEPT with cause 01.
  - Else reg_write=1, go to FETCH.
  - Overflow on unsigned ops is ignored.
- BRANCH: src_a=01, src_b=000, op 0110, pc_src=01, pc_write=alu_zero XOR (opcode==bne). Then FETCH.
- JUMP: pc_src=10, pc_write=1, then FETCH.
- EXCEPT: exception=1, pc_src=11, pc_write=1, exc_cause updated. Then FETCH.
- Latencies at mem_ready=1: lw 5, sw 4, R/I 4, beq/bne/j 3 cycles. Each mem_ready=0 cycle adds one.
- mem_read and mem_write are never both 1. Requests hold stable until mem_ready; mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.
- rst mid-access drops mem_read/mem_write immediately; no reg_write or pc_write escapes.

Decomposition:
- Shared package ctrl_pkg: opcode/funct constants, ALU operator codes, src_a/src_b/pc_src encodings, state enum, exc_cause codes.
- Sub-module alu_op_decode (combinational): opcode/funct -> alu_operator, src selects, is_signed, legal.

Test Plan:
- rst=1 during MEM_READ of lw -> all outputs 0 same cycle; after release: RESET, then FETCH with mem_read=1.
- R add (funct 100000), alu_overflow=1 in EXEC_R -> ALU_WB reg_write=0; EXCEPT exception=1, exc_cause=01, pc_src=11, pc_write=1.
- lw, mem_ready low 3 cycles in MEM_READ -> mem_read=1, iord=1 held 4 cycles; reg_write=1, mem_to_reg=1 once; total 8 cycles.
- beq with alu_zero=1 -> pc_write=1, pc_src=01; beq alu_zero=0 -> pc_write=0; bne alu_zero=0 -> pc_write=1.
- opcode 111111 -> DECODE -> EXCEPT, exc_cause=10, no reg_write/mem_write.
- sll (funct 000000) -> EXEC_R alu_operator=1000, src_a=10, src_b=101; ALU_WB reg_dst=1, reg_write=1.
